// File: rtl/mean_frame_ctrl_if.sv
// Sample-bank sequencing bus between mean_frame_ctrl and the RAM/accumulator datapath.
// The slave side is the controller; the master side is the source, the banks and the vote logic.
interface mean_frame_ctrl_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned IW = 7
);
  logic          di_vld;
  logic          in_rdy;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          acc_en;
  logic          acc_clr;
  logic          vote_strb;
  logic [IW-1:0] vote_idx;
  logic          frame_done;
  logic          busy;
  logic          ovf_err;

  modport master (
    output di_vld,
    input  in_rdy, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
           acc_en, acc_clr, vote_strb, vote_idx, frame_done, busy, ovf_err
  );

  modport slave (
    input  di_vld,
    output in_rdy, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
           acc_en, acc_clr, vote_strb, vote_idx, frame_done, busy, ovf_err
  );
endinterface

// File: rtl/mean_frame_ctrl.sv
// Ping-pong frame sequencer for repetition (majority-vote) decoding: linear bank writes,
// interleaved read-out of all copies of each bit, accumulator strobes aligned to RAM latency.
module mean_frame_ctrl #(
  parameter int unsigned N_BITS = 96,
  parameter int unsigned N_REP  = 10,
  parameter int unsigned AW     = 10,
  parameter int unsigned IW     = 7
) (
  input  logic            clk,
  input  logic            rst,
  mean_frame_ctrl_if.slave bus
);

  localparam int unsigned FRAME = N_BITS * N_REP;
  localparam int unsigned RW    = (N_REP > 1) ? $clog2(N_REP) : 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME - 1);
  localparam logic [AW-1:0] STRIDE    = AW'(N_BITS);
  localparam logic [RW-1:0] REP_LAST  = RW'(N_REP - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(N_BITS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state, state_n;
  logic [RW-1:0] rep, rep_n;
  logic [IW-1:0] k, k_n;
  logic [AW-1:0] rd_addr_n;
  logic          rd_en_n, frame_done_n, busy_n, rd_bank_n, drain_c;

  logic [AW-1:0] wr_cnt;
  logic          wr_sel, wr_sel_d;
  logic [1:0]    full, full_d;
  logic          accept_c, wr_last_c;

  // Bank occupancy: a bank turns full once its last address has actually been written.
  always_comb begin
    accept_c  = bus.di_vld & bus.in_rdy;
    wr_last_c = accept_c && (wr_cnt == LAST_ADDR);
    wr_sel_d  = wr_sel ^ wr_last_c;
    full_d    = full;
    if (bus.wr_en && (bus.wr_addr == LAST_ADDR)) full_d[bus.wr_bank] = 1'b1;
    if (drain_c) full_d[bus.rd_bank] = 1'b0;
  end

  // Write side: linear addressing into the bank currently being filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt      <= '0;
      wr_sel      <= 1'b0;
      full        <= '0;
      bus.in_rdy  <= 1'b1;
      bus.wr_en   <= 1'b0;
      bus.wr_bank <= 1'b0;
      bus.wr_addr <= '0;
      bus.ovf_err <= 1'b0;
    end else begin
      full       <= full_d;
      wr_sel     <= wr_sel_d;
      bus.in_rdy <= !full_d[wr_sel_d];
      bus.wr_en  <= accept_c;
      if (accept_c) begin
        bus.wr_addr <= wr_cnt;
        bus.wr_bank <= wr_sel;
        wr_cnt      <= wr_last_c ? '0 : wr_cnt + AW'(1);
      end
      if (bus.di_vld && !bus.in_rdy) bus.ovf_err <= 1'b1;
    end
  end

  // Read FSM next state; rd_addr steps by N_BITS and reloads k+1 when rep wraps.
  always_comb begin
    state_n      = state;
    rep_n        = rep;
    k_n          = k;
    rd_addr_n    = bus.rd_addr;
    rd_en_n      = 1'b0;
    frame_done_n = 1'b0;
    rd_bank_n    = bus.rd_bank;
    drain_c      = 1'b0;
    case (state)
      IDLE: begin
        if (full[bus.rd_bank]) begin
          state_n   = READ;
          rd_en_n   = 1'b1;
          rep_n     = '0;
          k_n       = '0;
          rd_addr_n = '0;
        end
      end
      READ: begin
        if ((rep == REP_LAST) && (k == BIT_LAST)) begin
          state_n      = DRAIN;
          frame_done_n = 1'b1;
        end else begin
          rd_en_n = 1'b1;
          if (rep == REP_LAST) begin
            rep_n     = '0;
            k_n       = k + IW'(1);
            rd_addr_n = AW'(k_n);
          end else begin
            rep_n     = rep + RW'(1);
            rd_addr_n = bus.rd_addr + STRIDE;
          end
        end
      end
      DRAIN: begin
        state_n   = IDLE;
        drain_c   = 1'b1;
        rd_bank_n = ~bus.rd_bank;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rep            <= '0;
      k              <= '0;
      bus.rd_addr    <= '0;
      bus.rd_en      <= 1'b0;
      bus.rd_bank    <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_n;
      rep            <= rep_n;
      k              <= k_n;
      bus.rd_addr    <= rd_addr_n;
      bus.rd_en      <= rd_en_n;
      bus.rd_bank    <= rd_bank_n;
      bus.frame_done <= frame_done_n;
      bus.busy       <= busy_n;
    end
  end

  // Accumulator controls trail the read strobe by the RAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.acc_en    <= 1'b0;
      bus.acc_clr   <= 1'b0;
      bus.vote_strb <= 1'b0;
      bus.vote_idx  <= '0;
    end else begin
      bus.acc_en    <= bus.rd_en;
      bus.acc_clr   <= bus.rd_en && (rep == RW'(0));
      bus.vote_strb <= bus.rd_en && (rep == REP_LAST);
      bus.vote_idx  <= k;
    end
  end

endmodule

// File: tb/tb_mean_frame_ctrl.sv
// Randomized scoreboard bench for mean_frame_ctrl: behavioural banks plus majority-vote
// consumer, expected writes and decisions queued by the stimulus and checked by a monitor.
module tb_mean_frame_ctrl;

  localparam int N   = 96;
  localparam int R   = 10;
  localparam int AW  = 10;
  localparam int IW  = 7;
  localparam int FR  = N * R;
  localparam int THR = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic di_data = 1'b0;
  logic d_reg = 1'b0;

  mean_frame_ctrl_if #(.AW(AW), .IW(IW)) bus ();

  mean_frame_ctrl #(.N_BITS(N), .N_REP(R), .AW(AW), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Datapath sample register the real system would place in front of the banks
  always @(posedge clk) d_reg <= di_data;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  int wr_q[$];
  int tb_wcnt = 0;
  int tb_wbank = 0;

  bit ram [0:1][0:(1<<AW)-1];
  int rd_pos = 0, rd_frame = 0, acc = 0;
  bit rdata = 1'b0;
  bit prev_rd_en = 1'b0, prev_fd = 1'b0, prev_in_rdy = 1'b1, prev_rst = 1'b1;
  int cyc = 0, fd_cnt = 0, acc_cnt = 0, vote_cnt = 0, stall_cnt = 0;
  int last_wr_cyc = 0, first_rd_cyc = 0;
  int mw, ms, me;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: behavioural banks, consumer accumulator and scoreboard pops
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rd_pos = 0; rd_frame = 0; acc = 0; rdata = 1'b0;
      prev_rd_en = 1'b0; prev_fd = 1'b0;
    end else begin
      if (!prev_rst) begin
        chk("acc_en_align", int'(bus.acc_en), int'(prev_rd_en));
        if (!prev_in_rdy) chk("in_rdy_release", int'(bus.in_rdy), int'(prev_fd));
      end
      chk("busy", int'(bus.busy), int'(bus.rd_en | bus.frame_done));
      if (!bus.in_rdy) stall_cnt++;
      if (bus.wr_en) begin
        if (wr_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL wr_unexpected: wr_en=1 at addr %0d, expected no write", bus.wr_addr);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_addr", int'(bus.wr_addr), mw & 32'hffff);
          chk("wr_bank", int'(bus.wr_bank), mw >> 16);
        end
        ram[bus.wr_bank][bus.wr_addr] = d_reg;
        if (int'(bus.wr_addr) == FR - 1) last_wr_cyc = cyc;
      end
      if (bus.acc_en) begin
        ms = bus.acc_clr ? int'(rdata) : acc + int'(rdata);
        acc = ms;
        acc_cnt++;
        if (bus.vote_strb) begin
          vote_cnt++;
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL vote_unexpected: vote_strb at idx %0d, expected none", bus.vote_idx);
          end else begin
            me = exp_q.pop_front();
            chk("vote_idx", int'(bus.vote_idx), me >> 1);
            chk("vote_bit", (ms >= THR) ? 1 : 0, me & 1);
          end
        end
      end
      if (bus.frame_done) begin
        fd_cnt++;
        chk("fd_with_last_vote", int'(bus.vote_strb), 1);
        chk("fd_read_count", rd_pos, FR);
        rd_pos = 0;
        rd_frame++;
      end
      if (bus.rd_en) begin
        chk("rd_addr", int'(bus.rd_addr), (rd_pos % R) * N + rd_pos / R);
        chk("rd_bank", int'(bus.rd_bank), rd_frame % 2);
        if (rd_pos == 0) first_rd_cyc = cyc;
        rd_pos++;
        rdata = ram[bus.rd_bank][bus.rd_addr];
      end
      prev_rd_en = bus.rd_en;
      prev_fd    = bus.frame_done;
    end
    prev_in_rdy = bus.in_rdy;
    prev_rst    = rst;
  end

  task automatic apply_rst();
    bus.di_vld = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    wr_q.delete();
    tb_wcnt = 0;
    tb_wbank = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // One frame: per-bit ones count (first four forced to 0, 10, 5, 4), rotated placement
  task automatic send_frame(input int gap_pct);
    int cnt [N];
    int rot [N];
    int idx = 0;
    int guard = 0;
    int kb, rp;
    for (int b = 0; b < N; b++) begin
      case (b)
        0: cnt[b] = 0;
        1: cnt[b] = R;
        2: cnt[b] = 5;
        3: cnt[b] = 4;
        default: cnt[b] = int'($urandom_range(R));
      endcase
      rot[b] = int'($urandom_range(R - 1));
      exp_q.push_back((b << 1) | ((cnt[b] >= THR) ? 1 : 0));
    end
    while (idx < FR && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (bus.in_rdy && (int'($urandom_range(99)) >= gap_pct)) begin
        kb = idx % N;
        rp = idx / N;
        bus.di_vld = 1'b1;
        di_data = (((rp + rot[kb]) % R) < cnt[kb]);
        wr_q.push_back((tb_wbank << 16) | tb_wcnt);
        tb_wcnt++;
        if (tb_wcnt == FR) begin
          tb_wcnt = 0;
          tb_wbank ^= 1;
        end
        idx++;
      end else begin
        bus.di_vld = 1'b0;
      end
    end
    if (idx < FR) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: sent %0d samples, expected %0d", idx, FR);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.di_vld = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (fd_cnt < target) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done: frame_done count %0d, expected %0d", fd_cnt, target);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_fd, b_acc, b_vote, b_stall, attempts, found;
    bus.di_vld = 1'b0;

    apply_rst();
    chk("rst_in_rdy", int'(bus.in_rdy), 1);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_rd_en", int'(bus.rd_en), 0);
    chk("rst_acc_en", int'(bus.acc_en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ovf", int'(bus.ovf_err), 0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    chk("rst_wr_bank", int'(bus.wr_bank), 0);
    chk("rst_rd_bank", int'(bus.rd_bank), 0);

    // Single gapless frame
    b_fd = fd_cnt; b_acc = acc_cnt; b_vote = vote_cnt;
    send_frame(0);
    idle();
    wait_done(b_fd + 1, 3000);
    repeat (3) @(negedge clk);
    chk("t1_rd_latency", first_rd_cyc - last_wr_cyc, 2);
    chk("t1_acc_cycles", acc_cnt - b_acc, FR);
    chk("t1_votes", vote_cnt - b_vote, N);
    chk("t1_frames", fd_cnt - b_fd, 1);
    chk("t1_busy_after", int'(bus.busy), 0);
    chk("t1_in_rdy_after", int'(bus.in_rdy), 1);

    // Three frames with 50% gaps: reader always keeps up
    b_fd = fd_cnt; b_stall = stall_cnt;
    repeat (3) send_frame(50);
    idle();
    wait_done(b_fd + 3, 8000);
    chk("t2_frames", fd_cnt - b_fd, 3);
    chk("t2_no_stall", stall_cnt - b_stall, 0);

    // Gapless source: writer must stall on in_rdy
    b_fd = fd_cnt; b_stall = stall_cnt;
    repeat (3) send_frame(0);
    idle();
    wait_done(b_fd + 3, 6000);
    chk("t3_frames", fd_cnt - b_fd, 3);
    chk("t3_stalled", (stall_cnt > b_stall) ? 1 : 0, 1);
    chk("t3_no_ovf", int'(bus.ovf_err), 0);

    // Overflow: push while in_rdy is low
    apply_rst();
    b_fd = fd_cnt;
    send_frame(0);
    send_frame(0);
    attempts = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!bus.in_rdy) begin
        bus.di_vld = 1'b1;
        attempts++;
      end else begin
        bus.di_vld = 1'b0;
        break;
      end
    end
    bus.di_vld = 1'b0;
    chk("t4_attempts", (attempts > 0) ? 1 : 0, 1);
    chk("t4_ovf_set", int'(bus.ovf_err), 1);
    chk("t4_wr_addr_held", int'(bus.wr_addr), FR - 1);
    wait_done(b_fd + 2, 4000);
    chk("t4_ovf_sticky", int'(bus.ovf_err), 1);
    apply_rst();
    chk("t4_ovf_cleared", int'(bus.ovf_err), 0);

    // Reset in the middle of READ
    b_fd = fd_cnt;
    send_frame(0);
    idle();
    found = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.rd_en && (int'(bus.rd_addr) == 500)) begin
        found = 1;
        break;
      end
    end
    chk("t5_reached_500", found, 1);
    #1 rst = 1'b1;
    exp_q.delete();
    wr_q.delete();
    tb_wcnt = 0;
    tb_wbank = 0;
    @(negedge clk);
    chk("t5_in_rdy", int'(bus.in_rdy), 1);
    chk("t5_rd_en", int'(bus.rd_en), 0);
    chk("t5_rd_addr", int'(bus.rd_addr), 0);
    chk("t5_acc_en", int'(bus.acc_en), 0);
    chk("t5_acc_clr", int'(bus.acc_clr), 0);
    chk("t5_vote_strb", int'(bus.vote_strb), 0);
    chk("t5_vote_idx", int'(bus.vote_idx), 0);
    chk("t5_frame_done", int'(bus.frame_done), 0);
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_wr_en", int'(bus.wr_en), 0);
    #1 rst = 1'b0;
    repeat (1200) @(negedge clk);
    chk("t5_no_frame_done", fd_cnt - b_fd, 0);
    chk("t5_idle", int'(bus.busy), 0);
    b_acc = acc_cnt;
    send_frame(0);
    idle();
    wait_done(b_fd + 1, 3000);
    repeat (3) @(negedge clk);
    chk("t5_fresh_frame", fd_cnt - b_fd, 1);
    chk("t5_fresh_acc", acc_cnt - b_acc, FR);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
